// File: rtl/cpu_types_pkg.sv
// Shared types for the MIPS datapath: machine word, HALT opcode and the
// fetch-stage state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam logic [5:0] HALT_OPCODE = 6'b111111;
  localparam word_t      INSTR_BYTES = 32'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT   = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  // Word-align an address by dropping the byte-offset bits.
  function automatic word_t word_align(input word_t addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory port, decode-side buffer, redirect
// and halt controls, plus the FSM state for observation.
//
// Handshake: the decode buffer transfers on a cycle where instr_valid and
// instr_ready are both 1 at the rising clock edge; while instr_valid=1 and
// instr_ready=0 the buffer (instr, instr_pc, instr_npc, instr_valid) holds
// stable unless a redirect or halt flushes it.
interface fetch_unit_if;
  import cpu_types_pkg::*;

  logic         imemREN;
  word_t        imemaddr;
  logic         ihit;
  word_t        imemload;
  word_t        instr;
  word_t        instr_pc;
  word_t        instr_npc;
  logic         instr_valid;
  logic         instr_ready;
  logic         redirect;
  word_t        redirect_addr;
  logic         halt;
  logic         halted;
  fetch_state_t state;

  modport master (
    output imemREN, imemaddr, instr, instr_pc, instr_npc, instr_valid,
           halted, state,
    input  ihit, imemload, instr_ready, redirect, redirect_addr, halt
  );

  modport slave (
    input  imemREN, imemaddr, instr, instr_pc, instr_npc, instr_valid,
           halted, state,
    output ihit, imemload, instr_ready, redirect, redirect_addr, halt
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues instruction-memory reads and
// holds one fetched word for decode; accepts redirects and stops on halt.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic          CLK,
  input  logic          nRST,
  fetch_unit_if.master  fif
);

  fetch_state_t state, next_state;
  word_t        pc, pc_next;
  word_t        instr_q, instr_pc_q, instr_npc_q;
  logic         valid_q;
  logic         buf_load, buf_clear;
  logic         buf_free;

  assign buf_free = !valid_q || fif.instr_ready;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      pc    <= PC_INIT;
    end else begin
      state <= next_state;
      pc    <= pc_next;
    end
  end

  // Priority: halt over redirect over normal fetch/consume.
  always_comb begin
    next_state = state;
    pc_next    = pc;
    buf_load   = 1'b0;
    buf_clear  = 1'b0;
    if (fif.halt) begin
      next_state = HALTED;
      buf_clear  = 1'b1;
    end else if (state == HALTED) begin
      next_state = HALTED;
    end else if (fif.redirect) begin
      next_state = REQ;
      pc_next    = word_align(fif.redirect_addr);
      buf_clear  = 1'b1;
    end else begin
      case (state)
        IDLE: next_state = REQ;
        REQ: begin
          if (fif.ihit && buf_free) begin
            buf_load = 1'b1;
            pc_next  = pc + INSTR_BYTES;
          end else if (valid_q && !fif.instr_ready) begin
            // A response arriving now is dropped; the same PC is refetched.
            next_state = WAIT;
          end else if (valid_q && fif.instr_ready) begin
            buf_clear = 1'b1;
          end
        end
        WAIT: begin
          if (valid_q && fif.instr_ready) begin
            buf_clear  = 1'b1;
            next_state = REQ;
          end else if (!valid_q) begin
            next_state = REQ;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      instr_q     <= '0;
      instr_pc_q  <= '0;
      instr_npc_q <= INSTR_BYTES;
      valid_q     <= 1'b0;
    end else if (buf_load) begin
      instr_q     <= fif.imemload;
      instr_pc_q  <= pc;
      instr_npc_q <= pc + INSTR_BYTES;
      valid_q     <= 1'b1;
    end else if (buf_clear) begin
      valid_q     <= 1'b0;
    end
  end

  // Memory-side outputs depend only on registered state and PC.
  assign fif.imemREN     = (state == REQ);
  assign fif.imemaddr    = pc;
  assign fif.halted      = (state == HALTED);
  assign fif.state       = state;
  assign fif.instr       = instr_q;
  assign fif.instr_pc    = instr_pc_q;
  assign fif.instr_npc   = instr_npc_q;
  assign fif.instr_valid = valid_q;

endmodule
